// File: rtl/piso_handshake_wrapped.sv
// piso_handshake_wrapped
//   Parallel-in / serial-out converter. A WIDTH-bit word is taken over a
//   valid/ready handshake and emitted LSB first, one bit per accepted beat,
//   on a serial valid/ready stream with a last-beat marker.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   INIT   reset value of the shift register (drives O while in reset/idle)
//
// Ports
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset, release sampled on CLK
//   I            parallel word to load
//   I_valid      upstream word valid
//   I_ready      block can accept a word (high only in IDLE)
//   O            current serial bit
//   O_valid      O holds a valid beat
//   O_last       current beat is the final beat of the word
//   O_ready      downstream accepts the beat
//
// Optional feature (macro PISO_PARITY_EN)
//   When defined, an even-parity bit of the loaded word is captured at load
//   time and sent as one extra beat after the data, carrying O_last.
//   When undefined, no parity register exists and O_last marks data bit
//   WIDTH-1.

module piso_handshake_wrapped #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic             O,
  output logic             O_valid,
  output logic             O_last,
  input  logic             O_ready
);

`ifdef PISO_PARITY_EN
  localparam int unsigned NBEATS = WIDTH + 1;
`else
  localparam int unsigned NBEATS = WIDTH;
`endif

  localparam int unsigned    CW       = $clog2(NBEATS + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(NBEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             beat_taken;
  logic             at_last;

`ifdef PISO_PARITY_EN
  // Counter value of the parity beat (the beat after the last data bit).
  localparam logic [CW-1:0] PAR_CNT = CW'(WIDTH);
  logic par_reg, par_next;
`endif

  // State registers; reset is asynchronous so outputs drop immediately.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_reg <= IDLE;
      shreg_reg <= INIT;
      cnt_reg   <= '0;
`ifdef PISO_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
`ifdef PISO_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // Next-state and output logic. Outputs depend only on registered state,
  // so neither I_valid nor O_ready reach any output combinationally.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
`ifdef PISO_PARITY_EN
    par_next   = par_reg;
`endif

    at_last    = (cnt_reg == LAST_CNT);
    I_ready    = (state_reg == IDLE);
    O_valid    = (state_reg == SHIFT);
    O_last     = (state_reg == SHIFT) && at_last;
`ifdef PISO_PARITY_EN
    O          = ((state_reg == SHIFT) && (cnt_reg == PAR_CNT)) ? par_reg
                                                                 : shreg_reg[0];
`else
    O          = shreg_reg[0];
`endif
    beat_taken = O_valid && O_ready;

    case (state_reg)
      IDLE: begin
        if (I_valid) begin
          shreg_next = I;
          cnt_next   = '0;
`ifdef PISO_PARITY_EN
          par_next   = ^I;
`endif
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_taken) begin
          shreg_next = shreg_reg >> 1;
          if (at_last) begin
            // Counter is left at its last value; it is cleared on the
            // next load, so it never wraps past NBEATS-1.
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/piso_handshake_wrapped.md
# piso_handshake_wrapped

Parallel-in/serial-out converter that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted beat, LSB first, on a serial valid/ready stream. It is the unloading counterpart to the parallel register wrappers: a captured register word goes in, and a serial link or bit-level consumer takes it out. It sits between register-level datapaths and serial sinks, under backpressure control from the sink.

## Interface

Parameters:
- WIDTH, 4, data word width in bits; must be ≥ 1.
- INIT, 0 (WIDTH bits), reset value of the internal shift register.

Ports:
- CLK  input  1  rising-edge clock.
- ASYNCRESETN  input  1  asynchronous, active-low reset. Asserting it clears all state immediately. Release is sampled synchronously by the design.
- I  input  WIDTH  parallel word to load.
- I_valid  input  1  upstream word is valid.
- I_ready  output  1  block can accept a word.
- O  output  1  current serial bit.
- O_valid  output  1  O holds a valid beat.
- O_last  output  1  current beat is the final beat of the word.
- O_ready  input  1  downstream accepts the beat.

## Operation

- State machine has two states: IDLE and SHIFT.
- IDLE:
  - I_ready=1, O_valid=0, O_last=0.
  - I_valid=1 at a rising edge loads I into the shift register, clears the beat counter and moves to SHIFT.
- SHIFT:
  - I_ready=0; I and I_valid are ignored.
  - O_valid=1 and O = shreg[0].
  - A beat is accepted when O_valid and O_ready are both high at a rising edge. On acceptance, shreg shifts right by one (MSB filled with 0) and the counter increments.
  - O_last=1 when counter == NBEATS-1. NBEATS is WIDTH without the parity option, WIDTH+1 with it.
  - When the last beat is accepted, the state returns to IDLE.
- O_ready low in SHIFT: O, O_valid and O_last hold their values; nothing shifts.
- The beat counter is ceil(log2(NBEATS+1)) bits wide and never wraps past NBEATS-1.
- WIDTH=1: the first beat is also the last beat, so O_last=1 on it (without parity).
- Outputs are registered or derived only from registered state. There is no combinational path from I_valid to the O outputs, and none from O_ready to I_ready.

## Timing

- Reset values: state=IDLE, shreg=INIT, counter=0, parity bit=0.
- Outputs during and after reset: I_ready=1, O_valid=0, O_last=0, O=INIT[0].
- Load latency: a word accepted at edge k gives O_valid=1 with bit 0 on O after edge k.
- Throughput: NBEATS beats per word plus one IDLE bubble cycle between words. I_ready rises the cycle after the last beat is accepted; there is no same-cycle reload.
- Reset mid-word: the word is discarded and all outputs take their reset values immediately, without waiting for a clock edge. No partial beats appear after release.
- I_valid and a final-beat acceptance in the same cycle: the word is not taken, because I_ready=0. The word is accepted one cycle later in IDLE if I_valid is still high.

## Configuration

- PISO_PARITY_EN defined:
  - At load, an even-parity bit P = XOR of all bits of I is captured.
  - After the WIDTH data beats, one extra beat carries O=P with O_last=1, so NBEATS=WIDTH+1.
  - The data beats then have O_last=0.
- PISO_PARITY_EN undefined:
  - No parity register exists and NBEATS=WIDTH.
  - O_last is asserted on data bit WIDTH-1.

## Test plan

- Reset values: hold ASYNCRESETN=0 with INIT=4'h5 → I_ready=1, O_valid=0, O_last=0, O=1.
- Basic word: WIDTH=4, O_ready=1, load I=4'hA → O beats 0,1,0,1 on four consecutive cycles.
  - O_last only on the 4th beat.
  - I_ready=1 on the cycle after.
  - With PISO_PARITY_EN: a 5th beat O=0 with O_last=1.
- Backpressure: load 4'h6, drive O_ready=0 for 3 cycles after beat 1 → O=1 and O_valid=1 are held.
  - The full sequence is still 0,1,1,0 with no beat lost or duplicated.
- Back-to-back words: I_valid held high with 4'hF then 4'h1 → beats 1,1,1,1, then one cycle with O_valid=0, then 1,0,0,0.
  - With PISO_PARITY_EN, parity beats are 0 and 1.
- Reset mid-word: assert ASYNCRESETN=0 after beat 2 of 4'hC → O_valid falls in the same cycle.
  - After release, the block is in IDLE and the next load of 4'h3 emits 1,1,0,0.
- Ignored input while busy: pulse I_valid with 4'hF during SHIFT of 4'h0 → serial output stays 0,0,0,0 and I_ready stays 0 throughout.
